// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment glyph constants, segment indices and width helper
// Segment vectors are {a,b,c,d,e,f,g}, active-high, bit 6 = a.
package seg7_pkg;

   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   localparam logic [6:0] SEG_BLANK   = 7'b0000000;
   localparam logic [6:0] SEG_GLYPH_0 = 7'b1111110;
   localparam logic [6:0] SEG_GLYPH_1 = 7'b0110000;
   localparam logic [6:0] SEG_GLYPH_2 = 7'b1101101;
   localparam logic [6:0] SEG_GLYPH_3 = 7'b1111001;
   localparam logic [6:0] SEG_GLYPH_4 = 7'b0110011;
   localparam logic [6:0] SEG_GLYPH_5 = 7'b1011011;
   localparam logic [6:0] SEG_GLYPH_6 = 7'b1011111;
   localparam logic [6:0] SEG_GLYPH_7 = 7'b1110000;
   localparam logic [6:0] SEG_GLYPH_8 = 7'b1111111;
   localparam logic [6:0] SEG_GLYPH_9 = 7'b1111011;
   localparam logic [6:0] SEG_GLYPH_A = 7'b1110111;
   localparam logic [6:0] SEG_GLYPH_B = 7'b0011111;
   localparam logic [6:0] SEG_GLYPH_C = 7'b1001110;
   localparam logic [6:0] SEG_GLYPH_D = 7'b0111101;
   localparam logic [6:0] SEG_GLYPH_E = 7'b1001111;
   localparam logic [6:0] SEG_GLYPH_F = 7'b1000111;

   // Width needed to count 0..value-1, never less than one bit.
   function automatic int seg7_clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << w) < value) w = w + 1;
      end
      if (w == 0) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational 4-bit code to 7-segment glyph decoder
// Codes 10..15 decode to letters only in hex mode; otherwise they are blank.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_mode,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'h0: seg = SEG_GLYPH_0;
         4'h1: seg = SEG_GLYPH_1;
         4'h2: seg = SEG_GLYPH_2;
         4'h3: seg = SEG_GLYPH_3;
         4'h4: seg = SEG_GLYPH_4;
         4'h5: seg = SEG_GLYPH_5;
         4'h6: seg = SEG_GLYPH_6;
         4'h7: seg = SEG_GLYPH_7;
         4'h8: seg = SEG_GLYPH_8;
         4'h9: seg = SEG_GLYPH_9;
         4'hA: seg = hex_mode ? SEG_GLYPH_A : SEG_BLANK;
         4'hB: seg = hex_mode ? SEG_GLYPH_B : SEG_BLANK;
         4'hC: seg = hex_mode ? SEG_GLYPH_C : SEG_BLANK;
         4'hD: seg = hex_mode ? SEG_GLYPH_D : SEG_BLANK;
         4'hE: seg = hex_mode ? SEG_GLYPH_E : SEG_BLANK;
         4'hF: seg = hex_mode ? SEG_GLYPH_F : SEG_BLANK;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed multi-digit 7-segment scan driver
// Digits are scanned one slot each; new values are swapped in only at frame wrap.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    hex_mode,
   input  logic                    blank_lz,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_done
);

   localparam int PRESC_W = seg7_clog2(REFRESH_DIV);
   localparam int IDX_W   = seg7_clog2(NUM_DIGITS);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

   logic [PRESC_W-1:0]             r_presc;
   logic [IDX_W-1:0]               r_idx;
   logic                           r_run;

   logic [NUM_DIGITS-1:0][3:0]     r_sh_digits;
   logic [NUM_DIGITS-1:0]          r_sh_dp;
   logic                           r_sh_hex;
   logic                           r_sh_blz;

   logic [NUM_DIGITS-1:0][3:0]     r_pd_digits;
   logic [NUM_DIGITS-1:0]          r_pd_dp;
   logic                           r_pd_hex;
   logic                           r_pd_blz;
   logic                           r_pd_valid;

   logic [6:0]                     r_seg;
   logic                           r_dp;
   logic [NUM_DIGITS-1:0]          r_dig;
   logic                           r_frame_done;

   logic                           w_tick;
   logic                           w_wrap;
   logic [3:0]                     w_code;
   logic [6:0]                     w_glyph;
   logic [NUM_DIGITS-1:0]          w_lz_zero;
   logic                           w_blank;
   logic [NUM_DIGITS-1:0]          w_dig_onehot;

   assign w_tick       = en && (r_presc == PRESC_LAST);
   assign w_wrap       = w_tick && (r_idx == IDX_LAST);
   assign w_code       = r_sh_digits[r_idx];
   assign w_dig_onehot = NUM_DIGITS'(1) << r_idx;

   seg7_hex_decode u_decode (
      .code     (w_code),
      .hex_mode (r_sh_hex),
      .seg      (w_glyph)
   );

   // w_lz_zero[k] is set when every digit from the MSD down to k is zero.
   always_comb begin
      logic acc;
      acc       = 1'b1;
      w_lz_zero = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         acc          = acc & (r_sh_digits[k] == 4'h0);
         w_lz_zero[k] = acc;
      end
   end

   assign w_blank = r_sh_blz && (r_idx != '0) && w_lz_zero[r_idx];

   // r_run holds the display dark until the first tick, so the partial slot after reset is never shown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_run        <= 1'b0;
         r_seg        <= '0;
         r_dp         <= 1'b0;
         r_dig        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_wrap;
         if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            r_run   <= 1'b1;
         end else if (en) begin
            r_presc <= r_presc + PRESC_W'(1);
         end

         if (en && !w_tick && r_run) begin
            r_dig <= w_dig_onehot;
            r_seg <= w_blank ? SEG_BLANK : w_glyph;
            r_dp  <= r_sh_dp[r_idx];
         end else begin
            r_dig <= '0;
            r_seg <= '0;
            r_dp  <= 1'b0;
         end
      end
   end

   // A load landing on the wrap tick bypasses pending so it shows from digit 0 of the new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_digits <= '0;
         r_sh_dp     <= '0;
         r_sh_hex    <= 1'b0;
         r_sh_blz    <= 1'b0;
         r_pd_digits <= '0;
         r_pd_dp     <= '0;
         r_pd_hex    <= 1'b0;
         r_pd_blz    <= 1'b0;
         r_pd_valid  <= 1'b0;
      end else if (load && w_wrap) begin
         r_sh_digits <= digits_in;
         r_sh_dp     <= dp_in;
         r_sh_hex    <= hex_mode;
         r_sh_blz    <= blank_lz;
         r_pd_valid  <= 1'b0;
      end else if (load) begin
         r_pd_digits <= digits_in;
         r_pd_dp     <= dp_in;
         r_pd_hex    <= hex_mode;
         r_pd_blz    <= blank_lz;
         r_pd_valid  <= 1'b1;
      end else if (w_wrap && r_pd_valid) begin
         r_sh_digits <= r_pd_digits;
         r_sh_dp     <= r_pd_dp;
         r_sh_hex    <= r_pd_hex;
         r_sh_blz    <= r_pd_blz;
         r_pd_valid  <= 1'b0;
      end
   end

   assign seg_out    = r_seg ^ {7{SEG_INV}};
   assign dp_out     = r_dp ^ SEG_INV;
   assign dig_sel    = r_dig ^ {NUM_DIGITS{DIG_INV}};
   assign frame_done = r_frame_done;

endmodule
